// File: rtl/main.sv
// ============================================================================
// Module   : main
// Brief    : Registered ALU datapath (operand regs A/B, result reg R) driven
//            by a 2-bit control FSM; optional {V,N,C,Z} flags via ALU_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module main #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       in_sel,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic [5:0]       out_sel,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       currState,
    output logic [1:0]       nextState
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]       flags
`endif
);

    localparam int c_SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        EXEC  = 2'b10,
        CLEAR = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] w_res;
    logic             w_valid;
    logic [c_SHW-1:0] w_shamt;

    assign out       = r_r;
    assign currState = r_state;
    assign nextState = w_next;
    assign w_shamt   = r_b[c_SHW-1:0];

    // Request priority is clear > load > persist; LOAD always falls into EXEC.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, EXEC: begin
                if (in_sel[0])      w_next = CLEAR;
                else if (in_sel[1]) w_next = LOAD;
                else if (in_sel[2]) w_next = EXEC;
                else                w_next = IDLE;
            end
            LOAD:    w_next = in_sel[0] ? CLEAR : EXEC;
            CLEAR:   w_next = in_sel[0] ? CLEAR : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Lowest set select bit wins; unknown bits fail their test and act as 0.
    always_comb begin
        w_res   = r_r;
        w_valid = 1'b1;
        if (out_sel[0])      w_res = r_a + r_b;
        else if (out_sel[1]) w_res = r_a - r_b;
        else if (out_sel[2]) w_res = r_a & r_b;
        else if (out_sel[3]) w_res = r_a | r_b;
        else if (out_sel[4]) w_res = r_a ^ r_b;
        else if (out_sel[5]) w_res = r_a << w_shamt;
        else                 w_valid = 1'b0;
    end

`ifdef ALU_FLAGS_EN
    logic [3:0] r_flags;
    logic [3:0] w_flags;
    logic       w_c;
    logic       w_v;

    assign flags = r_flags;

    always_comb begin
        w_c = 1'b0;
        w_v = 1'b0;
        if (out_sel[0]) begin
            w_c = (32'(r_a) + 32'(r_b)) > ((32'd1 << WIDTH) - 32'd1);
            w_v = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
        end else if (out_sel[1]) begin
            w_c = r_a < r_b;
            w_v = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
        end else if (out_sel[2] || out_sel[3] || out_sel[4]) begin
            w_c = 1'b0;
        end else if (out_sel[5]) begin
            // Last bit out of the top is A[WIDTH-shamt]; nothing leaves for shamt 0.
            for (int i = 1; i < WIDTH; i++) begin
                if (int'(w_shamt) == WIDTH - i) w_c = r_a[i];
            end
        end
        w_flags = {w_v, w_res[WIDTH-1], w_c, (w_res == '0)};
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_r     <= '0;
`ifdef ALU_FLAGS_EN
            r_flags <= 4'b0000;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                LOAD: begin
                    r_a <= num1;
                    r_b <= num2;
                end
                EXEC: begin
                    if (w_valid) begin
                        r_r     <= w_res;
`ifdef ALU_FLAGS_EN
                        r_flags <= w_flags;
`endif
                    end
                end
                CLEAR: begin
                    r_a     <= '0;
                    r_b     <= '0;
                    r_r     <= '0;
`ifdef ALU_FLAGS_EN
                    r_flags <= 4'b0000;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_main.sv
// ============================================================================
// Module   : tb_main
// Brief    : Directed + randomized self-checking bench for main, compared
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_main;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] in_sel;
    logic [7:0] num1;
    logic [7:0] num2;
    logic [5:0] out_sel;
    logic [7:0] out;
    logic [1:0] currState;
    logic [1:0] nextState;
`ifdef ALU_FLAGS_EN
    logic [3:0] flags;
`endif

    main #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_sel    (in_sel),
        .num1      (num1),
        .num2      (num2),
        .out_sel   (out_sel),
        .out       (out),
        .currState (currState),
        .nextState (nextState)
`ifdef ALU_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Reference model: state codes 0=IDLE 1=LOAD 2=EXEC 3=CLEAR
    int m_state, m_a, m_b, m_r, m_flags;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_next(input int s, input logic [2:0] req);
        if (req[0]) return 3;
        if (s == 3) return 0;
        if (s == 1) return 2;
        if (req[1]) return 1;
        if (req[2]) return 2;
        return 0;
    endfunction

    function automatic int op_index(input logic [5:0] sel);
        for (int i = 0; i < 6; i++) if (sel[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int alu(input int k, input int a, input int b);
        case (k)
            0: return (a + b) % 256;
            1: return (a - b + 256) % 256;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            default: return (a * (1 << (b % 8))) % 256;
        endcase
    endfunction

    function automatic int to_signed(input int a);
        return (a >= 128) ? a - 256 : a;
    endfunction

    function automatic int alu_flags(input int k, input int a, input int b);
        int r, c, v, sv, s;
        r = alu(k, a, b);
        c = 0;
        v = 0;
        if (k == 0) begin
            c  = (a + b > 255) ? 1 : 0;
            sv = to_signed(a) + to_signed(b);
            v  = (sv > 127 || sv < -128) ? 1 : 0;
        end else if (k == 1) begin
            c  = (a < b) ? 1 : 0;
            sv = to_signed(a) - to_signed(b);
            v  = (sv > 127 || sv < -128) ? 1 : 0;
        end else if (k == 5) begin
            s = b % 8;
            c = (s == 0) ? 0 : ((a >> (8 - s)) & 1);
        end
        return v * 8 + (r / 128) * 4 + c * 2 + ((r == 0) ? 1 : 0);
    endfunction

    task automatic model_edge();
        int k;
        k = op_index(out_sel);
        case (m_state)
            1: begin m_a = num1; m_b = num2; end
            2: if (k >= 0) begin
                   m_r     = alu(k, m_a, m_b);
                   m_flags = alu_flags(k, m_a, m_b);
               end
            3: begin m_a = 0; m_b = 0; m_r = 0; m_flags = 0; end
            default: ;
        endcase
        m_state = model_next(m_state, in_sel);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".state"}, 32'(currState), 32'(m_state));
        check({tag, ".out"}, 32'(out), 32'(m_r));
`ifdef ALU_FLAGS_EN
        check({tag, ".flags"}, 32'(flags), 32'(m_flags));
`endif
    endtask

    task automatic step(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                        input logic [5:0] o);
        in_sel  = s;
        num1    = a;
        num2    = b;
        out_sel = o;
        #1;
        check("nextState", 32'(nextState), 32'(model_next(m_state, s)));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs("step");
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        m_state = 0; m_a = 0; m_b = 0; m_r = 0; m_flags = 0;
        #1;
        check_outputs("reset");
        check("reset.nextState", 32'(nextState), 32'(model_next(0, in_sel)));
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0]  op_val [6];
        logic [5:0]  op_sel [6];
        logic [2:0]  s;
        logic [5:0]  o;

        op_sel = '{6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b000011};
        op_val = '{8'h3D, 8'h12, 8'h5F, 8'h4D, 8'h5C, 8'h71};

        rst = 1'b1; in_sel = 3'b000; num1 = 8'h00; num2 = 8'h00; out_sel = 6'b0;
        m_state = 0; m_a = 0; m_b = 0; m_r = 0; m_flags = 0;
        #1;
        check("rst.out", 32'(out), 32'h00);
        check("rst.state", 32'(currState), 32'h0);
        in_sel = 3'b010; #1;
        check("rst.next_load", 32'(nextState), 32'h1);
        in_sel = 3'b001; #1;
        check("rst.next_clear", 32'(nextState), 32'h3);
        in_sel = 3'b000;
        @(negedge clk);
        rst = 1'b0;

        step(3'b000, 8'h00, 8'h00, 6'b0);
        check("idle_hold", 32'(currState), 32'h0);

        step(3'b010, 8'h57, 8'h1A, 6'b000001);
        check("seq.load", 32'(currState), 32'h1);
        step(3'b010, 8'h57, 8'h1A, 6'b000001);
        check("seq.exec", 32'(currState), 32'h2);
        step(3'b010, 8'h57, 8'h1A, 6'b000001);
        check("add", 32'(out), 32'h71);
`ifdef ALU_FLAGS_EN
        check("add.flags", 32'(flags), 32'h0);
`endif

        for (int i = 0; i < 6; i++) begin
            step(3'b010, 8'h57, 8'h1A, op_sel[i]);
            step(3'b010, 8'h57, 8'h1A, op_sel[i]);
            check($sformatf("op%0d", i), 32'(out), 32'(op_val[i]));
        end

        step(3'b010, 8'h22, 8'h22, 6'b000010);
        step(3'b010, 8'h22, 8'h22, 6'b000010);
        check("sub_zero", 32'(out), 32'h00);
`ifdef ALU_FLAGS_EN
        check("sub_zero.flags", 32'(flags), 32'h1);
`endif
        step(3'b000, 8'h22, 8'h22, 6'b000010);
        step(3'b000, 8'h22, 8'h22, 6'b000010);
        check("back_idle", 32'(currState), 32'h0);
        check("idle_out", 32'(out), 32'h00);

        step(3'b100, 8'h00, 8'h22, 6'b000001);
        check("persist.state", 32'(currState), 32'h2);
        step(3'b100, 8'h00, 8'h22, 6'b000001);
        check("persist.out", 32'(out), 32'h44);
        step(3'b001, 8'h00, 8'h22, 6'b000001);
        check("clear.state", 32'(currState), 32'h3);
        step(3'b000, 8'h00, 8'h22, 6'b000001);
        check("clear.out", 32'(out), 32'h00);
        check("clear.idle", 32'(currState), 32'h0);

        step(3'b010, 8'hA5, 8'h3C, 6'b000001);
        check("preload", 32'(currState), 32'h1);
        in_sel = 3'b100;
        pulse_reset();
        step(3'b100, 8'h00, 8'h00, 6'b000001);
        step(3'b000, 8'h00, 8'h00, 6'b000001);
        check("lost_operands", 32'(out), 32'h00);

        for (int n = 0; n < 400; n++) begin
            s = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) s[0] = 1'b0;
            if ($urandom_range(0, 4) == 0) o = 6'($urandom_range(0, 63));
            else                           o = 6'(1 << $urandom_range(0, 5));
            if ($urandom_range(0, 49) == 0) begin
                in_sel = s;
                pulse_reset();
            end
            step(s, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), o);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
